// File: rtl/ahb_pkg.sv
// Shared AHB encodings, slave FSM states and transfer-decoding helpers.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ERR1  = 2'd2,
        ST_ERR2  = 2'd3
    } state_e;

    // Oversized transfers and misaligned half/word transfers get an ERROR response.
    function automatic logic isIllegal(input logic [2:0] size, input logic [1:0] addrLo);
        logic bad;
        bad = 1'b0;
        if (size > HSIZE_WORD) begin
            bad = 1'b1;
        end else if ((size == HSIZE_HALF) && addrLo[0]) begin
            bad = 1'b1;
        end else if ((size == HSIZE_WORD) && (addrLo != 2'b00)) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    // Byte lanes of a 32-bit word touched by a legal transfer.
    function automatic logic [3:0] byteLanes(input logic [2:0] size, input logic [1:0] addrLo);
        logic [3:0] lanes;
        if (size == HSIZE_BYTE) begin
            lanes = 4'b0001 << addrLo;
        end else if (size == HSIZE_HALF) begin
            lanes = addrLo[1] ? 4'b1100 : 4'b0011;
        end else begin
            lanes = 4'b1111;
        end
        return lanes;
    endfunction

endpackage

// File: rtl/sram_bytewe.sv
// DEPTH x 32 storage with per-byte write enables and an asynchronous read
// port driven by the slave's registered word index. Contents are never reset.
module sram_bytewe #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          HCLK,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Commit each enabled byte lane of the write word on the rising edge.
    always_ff @(posedge HCLK) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: zero-wait reads, byte-lane writes, optional wait
// states and a two-cycle ERROR response for illegal size/alignment.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int AW = $clog2(DEPTH);

    state_e        r_state;
    logic          r_readyOut;
    logic [1:0]    r_resp;
    logic [1:0]    r_waitCnt;
    logic          r_pending;
    logic          r_write;
    logic [2:0]    r_size;
    logic [1:0]    r_addrLo;
    logic [AW-1:0] r_index;

    logic          w_accept;
    logic          w_illegal;
    logic          w_complete;
    logic [3:0]    w_we;
    logic [31:0]   w_memRdata;
    logic          w_unused;

    assign w_accept   = HSEL & HREADYIN &
                        ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
    assign w_illegal  = isIllegal(HSIZE, HADDR[1:0]);
    assign w_complete = r_pending & (r_state == ST_READY);
    assign w_we       = (w_complete & r_write) ? byteLanes(r_size, r_addrLo) : 4'b0000;
    assign w_unused   = ^HADDR[31:AW+2];

    // Address-phase capture and response sequencing; a new transfer may be
    // taken in the same cycle a data phase or the second ERROR cycle completes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= ST_READY;
            r_readyOut <= 1'b1;
            r_resp     <= HRESP_OKAY;
            r_waitCnt  <= 2'd0;
            r_pending  <= 1'b0;
            r_write    <= 1'b0;
            r_size     <= 3'd0;
            r_addrLo   <= 2'd0;
            r_index    <= '0;
        end else begin
            case (r_state)
                ST_READY, ST_ERR2: begin
                    r_state    <= ST_READY;
                    r_readyOut <= 1'b1;
                    r_resp     <= HRESP_OKAY;
                    r_pending  <= 1'b0;
                    if (w_accept) begin
                        r_index  <= HADDR[AW+1:2];
                        r_addrLo <= HADDR[1:0];
                        r_write  <= HWRITE;
                        r_size   <= HSIZE;
                        if (w_illegal) begin
                            r_state    <= ST_ERR1;
                            r_readyOut <= 1'b0;
                            r_resp     <= HRESP_ERROR;
                        end else begin
                            r_pending <= 1'b1;
                            if (WAIT_STATES > 0) begin
                                r_state    <= ST_WAIT;
                                r_readyOut <= 1'b0;
                                r_waitCnt  <= 2'(WAIT_STATES - 1);
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    r_resp <= HRESP_OKAY;
                    if (r_waitCnt == 2'd0) begin
                        r_state    <= ST_READY;
                        r_readyOut <= 1'b1;
                    end else begin
                        r_waitCnt <= r_waitCnt - 2'd1;
                    end
                end
                ST_ERR1: begin
                    r_state    <= ST_ERR2;
                    r_readyOut <= 1'b1;
                    r_resp     <= HRESP_ERROR;
                end
                default: begin
                    r_state    <= ST_READY;
                    r_readyOut <= 1'b1;
                    r_resp     <= HRESP_OKAY;
                    r_pending  <= 1'b0;
                end
            endcase
        end
    end

    sram_bytewe #(
        .DEPTH (DEPTH)
    ) u_sram (
        .HCLK    (HCLK),
        .i_we    (w_we),
        .i_waddr (r_index),
        .i_wdata (HWDATA),
        .i_raddr (r_index),
        .o_rdata (w_memRdata)
    );

    assign HREADYOUT = r_readyOut;
    assign HRESP     = r_resp;
    assign HRDATA    = (r_pending & ~r_write) ? w_memRdata : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Two slaves (0 and 2 wait states) share one bus in lockstep and are checked
// every cycle against a transaction-level response-script and byte-memory model.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        logic        ready;
        logic [1:0]  resp;
        logic        chkRead;
        logic        doWrite;
        int          idx;
        logic [3:0]  lanes;
        logic [31:0] wdata;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADYIN;
    logic        ready0, ready2;
    logic [1:0]  resp0, resp2;
    logic [31:0] rdata0, rdata2;

    exp_t        q0[$];
    exp_t        q2[$];
    xfer_t       stimQ[$];
    logic [31:0] mdl [DEPTH];

    int          total = 0;
    int          bad = 0;
    int          randLeft = 0;
    int          lowCnt0 = 0;
    int          errCnt0 = 0;
    int          run2 = 0;
    int          lastRun2 = 0;
    logic [31:0] lastRead0 = 32'h0;
    logic [31:0] lastRead2 = 32'h0;
    logic [31:0] wdNext = 32'h0;
    logic        wdPending = 1'b0;

    assign HREADYIN = ready0 & ready2;

    always #5 HCLK = ~HCLK;

    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADYIN(HREADYIN), .HREADYOUT(ready0), .HRESP(resp0), .HRDATA(rdata0)
    );

    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(2)) dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADYIN(HREADYIN), .HREADYOUT(ready2), .HRESP(resp2), .HRDATA(rdata2)
    );

    task automatic cmp(input string what, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", what, act, want, $time);
        end
    endtask

    function automatic exp_t mkExp(input logic rdy, input logic [1:0] rsp);
        exp_t e;
        e.ready = rdy; e.resp = rsp; e.chkRead = 1'b0; e.doWrite = 1'b0;
        e.idx = 0; e.lanes = 4'b0; e.wdata = 32'h0;
        return e;
    endfunction

    function automatic xfer_t mkXfer(input logic wr, input logic [2:0] sz,
                                     input logic [31:0] a, input logic [31:0] wd);
        xfer_t x;
        x.sel = 1'b1; x.trans = HTRANS_NONSEQ; x.write = wr;
        x.size = sz; x.addr = a; x.wdata = wd;
        return x;
    endfunction

    function automatic xfer_t idleXfer();
        xfer_t x;
        x = mkXfer(1'b0, 3'd0, 32'h0, 32'h0);
        x.sel = 1'b0; x.trans = HTRANS_IDLE;
        return x;
    endfunction

    function automatic xfer_t randXfer();
        xfer_t x;
        logic [31:0] a;
        x.sel   = ($urandom_range(0, 9) != 0);
        x.trans = 2'($urandom_range(0, 3));
        x.write = 1'($urandom_range(0, 1));
        x.size  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
        a = $urandom();
        a[9:6] = 4'b0000;
        x.addr  = a;
        x.wdata = $urandom();
        return x;
    endfunction

    // Response script per slave: illegal -> two ERROR cycles; legal -> ws
    // stall cycles then one completing cycle carrying the read/write effect.
    task automatic scheduleXfer(input xfer_t x);
        int nb, lo, m, idx, ws;
        logic legal;
        exp_t e;
        nb = 1 << x.size;
        lo = int'(x.addr[1:0]);
        legal = (x.size <= 3'd2) && ((lo % nb) == 0);
        m = ((1 << nb) - 1) << lo;
        idx = int'(x.addr[AW+1:2]);
        for (int d = 0; d < 2; d++) begin
            ws = (d == 0) ? 0 : 2;
            if (!legal) begin
                e = mkExp(1'b0, HRESP_ERROR);
                if (d == 0) q0.push_back(e); else q2.push_back(e);
                e = mkExp(1'b1, HRESP_ERROR);
                if (d == 0) q0.push_back(e); else q2.push_back(e);
            end else begin
                for (int k = 0; k < ws; k++) begin
                    e = mkExp(1'b0, HRESP_OKAY);
                    q2.push_back(e);
                end
                e = mkExp(1'b1, HRESP_OKAY);
                e.chkRead = !x.write;
                e.doWrite = x.write;
                e.idx = idx;
                e.lanes = m[3:0];
                e.wdata = x.wdata;
                if (d == 0) q0.push_back(e); else q2.push_back(e);
            end
        end
    endtask

    task automatic driveXfer(input xfer_t x);
        HSEL = x.sel; HTRANS = x.trans; HWRITE = x.write;
        HSIZE = x.size; HADDR = x.addr;
    endtask

    task automatic checkOutput(input int which, input exp_t e, input logic rdy,
                               input logic [1:0] rsp, input logic [31:0] rd);
        string nm;
        nm = (which == 0) ? "ws0" : "ws2";
        cmp($sformatf("%s hreadyout", nm), {31'h0, rdy}, {31'h0, e.ready});
        cmp($sformatf("%s hresp", nm), {30'h0, rsp}, {30'h0, e.resp});
        if (e.chkRead) begin
            cmp($sformatf("%s hrdata word %0d", nm, e.idx), rd, mdl[e.idx]);
            if (which == 0) lastRead0 = rd; else lastRead2 = rd;
        end
        if (e.doWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (e.lanes[b]) mdl[e.idx][8*b +: 8] = e.wdata[8*b +: 8];
            end
        end
    endtask

    task automatic applyStimulus();
        exp_t e0, e2;
        xfer_t x;
        @(posedge HCLK);
        #1;
        if (wdPending) begin
            HWDATA = wdNext;
            wdPending = 1'b0;
        end
        @(negedge HCLK);
        if (q0.size() > 0) e0 = q0.pop_front(); else e0 = mkExp(1'b1, HRESP_OKAY);
        if (q2.size() > 0) e2 = q2.pop_front(); else e2 = mkExp(1'b1, HRESP_OKAY);
        checkOutput(0, e0, ready0, resp0, rdata0);
        checkOutput(2, e2, ready2, resp2, rdata2);
        if (!ready0) lowCnt0++;
        if (resp0 == HRESP_ERROR) errCnt0++;
        if (!ready2) begin
            run2++;
        end else begin
            if (run2 > 0) lastRun2 = run2;
            run2 = 0;
        end
        if (e0.ready && e2.ready) begin
            if (stimQ.size() > 0) begin
                x = stimQ.pop_front();
            end else if (randLeft > 0) begin
                x = randXfer();
                randLeft--;
            end else begin
                x = idleXfer();
            end
            driveXfer(x);
            if (x.sel && x.trans[1]) begin
                scheduleXfer(x);
                wdNext = x.wdata;
                wdPending = 1'b1;
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((stimQ.size() > 0 || randLeft > 0 || q0.size() > 0 || q2.size() > 0) && n < budget) begin
            applyStimulus();
            n++;
        end
        if (stimQ.size() > 0 || randLeft > 0 || q0.size() > 0 || q2.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: %0d cycles used, expected completion within %0d", n, budget);
            stimQ.delete(); q0.delete(); q2.delete(); randLeft = 0;
        end
    endtask

    initial begin
        HRESETn = 1'b0;
        driveXfer(idleXfer());
        HWDATA = 32'h0;
        repeat (2) @(negedge HCLK);
        cmp("reset hreadyout ws0", {31'h0, ready0}, 32'h1);
        cmp("reset hreadyout ws2", {31'h0, ready2}, 32'h1);
        cmp("reset hresp ws0", {30'h0, resp0}, 32'h0);
        cmp("reset hresp ws2", {30'h0, resp2}, 32'h0);
        cmp("reset hrdata ws0", rdata0, 32'h0);
        cmp("reset hrdata ws2", rdata2, 32'h0);
        HRESETn = 1'b1;

        for (int i = 0; i < 16; i++) stimQ.push_back(mkXfer(1'b1, 3'd2, 32'(i * 4), $urandom()));
        drain(200);

        lowCnt0 = 0;
        stimQ.push_back(mkXfer(1'b1, 3'd2, 32'h10, 32'hDEADBEEF));
        stimQ.push_back(mkXfer(1'b0, 3'd2, 32'h10, 32'h0));
        drain(50);
        cmp("word rd ws0", lastRead0, 32'hDEADBEEF);
        cmp("word rd ws2", lastRead2, 32'hDEADBEEF);
        cmp("no stall ws0", 32'(lowCnt0), 32'd0);

        stimQ.push_back(mkXfer(1'b1, 3'd2, 32'h10, 32'h11223344));
        stimQ.push_back(mkXfer(1'b1, 3'd0, 32'h13, 32'hAA000000));
        stimQ.push_back(mkXfer(1'b0, 3'd2, 32'h10, 32'h0));
        drain(50);
        cmp("byte merge ws0", lastRead0, 32'hAA223344);
        cmp("byte merge ws2", lastRead2, 32'hAA223344);

        stimQ.push_back(mkXfer(1'b1, 3'd2, 32'h00, 32'h0BADF00D));
        drain(50);
        errCnt0 = 0;
        stimQ.push_back(mkXfer(1'b0, 3'd2, 32'h02, 32'h0));
        stimQ.push_back(mkXfer(1'b1, 3'd2, 32'h02, 32'hFFFFFFFF));
        stimQ.push_back(mkXfer(1'b0, 3'd2, 32'h00, 32'h0));
        drain(50);
        cmp("error cycles ws0", 32'(errCnt0), 32'd4);
        cmp("mem after error ws0", lastRead0, 32'h0BADF00D);
        cmp("mem after error ws2", lastRead2, 32'h0BADF00D);

        stimQ.push_back(mkXfer(1'b1, 3'd2, 32'h20, 32'h20202020));
        stimQ.push_back(mkXfer(1'b0, 3'd2, 32'h20, 32'h0));
        drain(50);
        cmp("wait run ws2", 32'(lastRun2), 32'd2);
        cmp("wait rd ws2", lastRead2, 32'h20202020);

        stimQ.push_back(mkXfer(1'b1, 3'd2, 32'h30, 32'h00000055));
        stimQ.push_back(mkXfer(1'b0, 3'd2, 32'h30, 32'h0));
        drain(50);
        cmp("bypass ws0", lastRead0, 32'h00000055);
        cmp("bypass ws2", lastRead2, 32'h00000055);

        randLeft = 400;
        drain(5000);

        stimQ.push_back(mkXfer(1'b1, 3'd2, 32'h3C, 32'h12345678));
        drain(50);
        driveXfer(mkXfer(1'b1, 3'd2, 32'h3C, 32'hCAFEBABE));
        @(posedge HCLK);
        #1;
        HWDATA = 32'hCAFEBABE;
        driveXfer(idleXfer());
        @(negedge HCLK);
        cmp("mid write stall ws2", {31'h0, ready2}, 32'h0);
        HRESETn = 1'b0;
        #1;
        cmp("async rst hreadyout ws0", {31'h0, ready0}, 32'h1);
        cmp("async rst hreadyout ws2", {31'h0, ready2}, 32'h1);
        cmp("async rst hresp ws2", {30'h0, resp2}, 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        stimQ.push_back(mkXfer(1'b0, 3'd2, 32'h3C, 32'h0));
        drain(50);
        cmp("aborted write ws0", lastRead0, 32'h12345678);
        cmp("aborted write ws2", lastRead2, 32'h12345678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
